// File: rtl/boot_loader_pkg.sv
// Shared types and header layout for the boot loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam int HDR_BASE_MSB = 15;
    localparam int HDR_BASE_LSB = 8;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 0;

    // The loader accepts stream words only while an image is being received.
    function automatic logic isLoaderState(input state_t s);
        return (s == HDR) || (s == LOAD) || (s == CHECK);
    endfunction

endpackage

// File: rtl/ram_port_mux.sv
// Selects which side owns the blram port: the loader write register or the core.
module ram_port_mux #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 16
) (
    input  logic             runMode,
    input  logic             ldWrEn,
    input  logic [SIZE-1:0]  ldAddr,
    input  logic [WIDTH-1:0] ldData,
    input  logic             cpuWrEn,
    input  logic [SIZE-1:0]  cpuAddr,
    input  logic [WIDTH-1:0] cpuData,
    output logic             wrEn,
    output logic [SIZE-1:0]  addr,
    output logic [WIDTH-1:0] data
);

    assign wrEn = runMode ? cpuWrEn : ldWrEn;
    assign addr = runMode ? cpuAddr : ldAddr;
    assign data = runMode ? cpuData : ldData;

endmodule

// File: rtl/boot_loader.sv
// Streams a checksummed program image into blram while holding TinyMIPS in
// reset, then releases the core and hands it the RAM port.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             load_req,
    input  logic             cpu_wrEn,
    input  logic [SIZE-1:0]  cpu_addr,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             wrEn,
    output logic [SIZE-1:0]  addr_toRAM,
    output logic [WIDTH-1:0] data_toRAM,
    output logic             cpu_rst,
    output logic             busy,
    output logic             err,
    output logic [7:0]       words_loaded
);

    state_t           state;
    logic [SIZE-1:0]  baseAddr;
    logic [7:0]       imgLen;
    logic [7:0]       wordCnt;
    logic [WIDTH-1:0] checksumAcc;
    logic             ldWrEn;
    logic [SIZE-1:0]  ldAddr;
    logic [WIDTH-1:0] ldData;
    logic             transfer;

    assign in_ready     = isLoaderState(state);
    assign transfer     = in_valid & in_ready;
    assign busy         = in_ready;
    assign err          = (state == ERROR);
    assign cpu_rst      = (state != RUN);
    assign words_loaded = wordCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HDR;
            baseAddr    <= '0;
            imgLen      <= '0;
            wordCnt     <= '0;
            checksumAcc <= '0;
            ldWrEn      <= 1'b0;
            ldAddr      <= '0;
            ldData      <= '0;
        end else begin
            // NOTE: non-blocking default makes the write a one-cycle pulse;
            // any branch below that issues a write simply overrides it.
            ldWrEn <= 1'b0;
            case (state)
                HDR: if (transfer) begin
                    baseAddr    <= in_data[HDR_BASE_MSB:HDR_BASE_LSB];
                    imgLen      <= in_data[HDR_LEN_MSB:HDR_LEN_LSB];
                    wordCnt     <= '0;
                    checksumAcc <= '0;
                    state       <= (in_data[HDR_LEN_MSB:HDR_LEN_LSB] == '0) ? CHECK : LOAD;
                end
                LOAD: if (transfer) begin
                    ldWrEn      <= 1'b1;
                    ldAddr      <= baseAddr + wordCnt;
                    ldData      <= in_data;
                    checksumAcc <= checksumAcc + in_data;
                    wordCnt     <= wordCnt + 8'd1;
                    if (wordCnt == imgLen - 8'd1) state <= CHECK;
                end
                CHECK: if (transfer) begin
                    state <= (in_data == checksumAcc) ? RUN : ERROR;
                end
                RUN, ERROR: if (load_req) state <= HDR;
                default: state <= HDR;
            endcase
        end
    end

    ram_port_mux #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_ram_port_mux (
        .runMode (state == RUN),
        .ldWrEn  (ldWrEn),
        .ldAddr  (ldAddr),
        .ldData  (ldData),
        .cpuWrEn (cpu_wrEn),
        .cpuAddr (cpu_addr),
        .cpuData (cpu_data),
        .wrEn    (wrEn),
        .addr    (addr_toRAM),
        .data    (data_toRAM)
    );

endmodule
